// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into ON_CYCLES-long output windows, each followed by
// at least OFF_CYCLES of guard gap. Events that arrive during a window or gap are
// queued, up to QUEUE_DEPTH of them; further events are dropped and flagged.
module pulse_stretcher #(
    parameter bit          INVERT_LOGIC = 1'b0,
    parameter int unsigned ON_CYCLES    = 5_000_000,
    parameter int unsigned OFF_CYCLES   = 2_500_000,
    parameter int unsigned QUEUE_DEPTH  = 7
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pulse_in,
    output logic                               signal_out,
    output logic                               busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending,
    output logic                               dropped
);

    localparam int unsigned PEND_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [PEND_W-1:0]   pend_d;
    logic                drop_d;

    // Next state, shared window/gap counter and event queue.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pending;
        drop_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pulse_in) begin
                    state_d = S_ON;
                    cnt_d   = ON_LOAD;
                end
            end

            S_ON: begin
                if (cnt_q == '0) begin
                    state_d = S_OFF;
                    cnt_d   = OFF_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (pulse_in) begin
                    if (pending < PEND_MAX) pend_d = pending + PEND_W'(1);
                    else                    drop_d = 1'b1;
                end
            end

            S_OFF: begin
                if (cnt_q == '0) begin
                    // End of gap: a queued event wins; a same-cycle pulse then takes its slot.
                    if (pending != '0) begin
                        state_d = S_ON;
                        cnt_d   = ON_LOAD;
                        if (!pulse_in) pend_d = pending - PEND_W'(1);
                    end else if (pulse_in) begin
                        state_d = S_ON;
                        cnt_d   = ON_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (pulse_in) begin
                        if (pending < PEND_MAX) pend_d = pending + PEND_W'(1);
                        else                    drop_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pend_d  = '0;
            end
        endcase
    end

    // State and registered outputs, derived from the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pending    <= '0;
            dropped    <= 1'b0;
            busy       <= 1'b0;
            signal_out <= INVERT_LOGIC;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending    <= pend_d;
            dropped    <= drop_d;
            busy       <= (state_d != S_IDLE);
            signal_out <= (state_d == S_ON) ^ INVERT_LOGIC;
        end
    end

endmodule
